exc_ctrl: RTL and testbench

//  Exception/interrupt sequencer between the MEM stage and cp0. Each cycle it

---
 rtl/exc_ctrl_pkg.sv | 37 +++
 rtl/exc_prio_enc.sv | 44 ++++
 rtl/exc_ctrl.sv | 130 +++++++++++++
 tb/tb_exc_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared excepttype codes, cp0 addresses, flag indices and FSM states
package exc_ctrl_pkg;

  localparam logic [31:0] DEF_EXC_VECTOR = 32'hBFC0_0380;
  localparam int          DEF_DRAIN_MAX  = 8;

  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;

  // Bit positions within m_flags_i
  localparam int FLAG_ADEL_IF = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_OV      = 2;
  localparam int FLAG_SYS     = 3;
  localparam int FLAG_BRK     = 4;
  localparam int FLAG_ADEL_LD = 5;
  localparam int FLAG_ADES    = 6;
  localparam int FLAG_ERET    = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT
  } exc_state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - combinational priority encoder: flags + int_req -> event, code, bad address
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic        int_req,
  input  logic [7:0]  flags,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  output logic        evt,
  output logic [4:0]  code,
  output logic [31:0] bad_addr
);

  always_comb begin
    evt      = 1'b1;
    code     = EXC_NONE;
    bad_addr = '0;
    if (int_req) begin
      code = EXC_INT;
    end else if (flags[FLAG_ADEL_IF]) begin
      code     = EXC_ADEL;
      bad_addr = pc;
    end else if (flags[FLAG_RI]) begin
      code = EXC_RI;
    end else if (flags[FLAG_OV]) begin
      code = EXC_OV;
    end else if (flags[FLAG_SYS]) begin
      code = EXC_SYS;
    end else if (flags[FLAG_BRK]) begin
      code = EXC_BP;
    end else if (flags[FLAG_ADEL_LD]) begin
      code     = EXC_ADEL;
      bad_addr = addr;
    end else if (flags[FLAG_ADES]) begin
      code     = EXC_ADES;
      bad_addr = addr;
    end else if (flags[FLAG_ERET]) begin
      code = EXC_ERET;
    end else begin
      evt = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt sequencer between MEM stage and cp0
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int          DRAIN_MAX  = DEF_DRAIN_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid_i,
  input  logic [31:0] m_pc_i,
  input  logic        m_dslot_i,
  input  logic [7:0]  m_flags_i,
  input  logic [31:0] m_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        fwd_we_i,
  input  logic [4:0]  fwd_addr_i,
  input  logic [31:0] fwd_data_i,
  input  logic        mem_busy_i,
  input  logic        if_ready_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] pc_o,
  output logic        dslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic [31:0] newpc_o,
  output logic        newpc_vld_o
);

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_MAX - 1);

  exc_state_t  state_q, state_d;
  logic [4:0]  code_q;
  logic [31:0] pc_q, bad_q, newpc_q;
  logic        dslot_q;
  logic [2:0]  cnt_q;

  logic [31:0] eff_status, eff_cause;
  logic        int_req, enc_evt, evt;
  logic [4:0]  enc_code;
  logic [31:0] enc_bad;
  logic        unused_bits;

  // An mtc0 still in flight must already count, so fold it in ahead of cp0.
  always_comb begin
    eff_status = status_i;
    eff_cause  = cause_i;
    if (fwd_we_i && fwd_addr_i == CP0_STATUS) eff_status = fwd_data_i;
    if (fwd_we_i && fwd_addr_i == CP0_CAUSE)  eff_cause[9:8] = fwd_data_i[9:8];
  end

  assign int_req = |(eff_cause[15:8] & eff_status[15:8]) && eff_status[0] && !eff_status[1];
  assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

  exc_prio_enc u_prio (
    .int_req  (int_req),
    .flags    (m_flags_i),
    .pc       (m_pc_i),
    .addr     (m_addr_i),
    .evt      (enc_evt),
    .code     (enc_code),
    .bad_addr (enc_bad)
  );

  assign evt = m_valid_i && enc_evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    excepttype_o = '0;
    flush_o      = 1'b0;
    stall_o      = 1'b0;
    newpc_vld_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (evt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall_o = 1'b1;
        if (!mem_busy_i || cnt_q == DRAIN_LAST) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        excepttype_o = {27'd0, code_q};
        flush_o      = 1'b1;
        stall_o      = 1'b1;
        state_d      = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        newpc_vld_o = 1'b1;
        if (if_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q  <= EXC_NONE;
      pc_q    <= '0;
      dslot_q <= 1'b0;
      bad_q   <= '0;
      cnt_q   <= '0;
      newpc_q <= '0;
    end else begin
      if (state_q == ST_IDLE && evt) begin
        code_q  <= enc_code;
        pc_q    <= m_pc_i;
        dslot_q <= m_dslot_i;
        bad_q   <= enc_bad;
        cnt_q   <= '0;
      end
      if (state_q == ST_DRAIN && cnt_q != 3'd7) cnt_q <= cnt_q + 3'd1;
      // EPC is sampled in COMMIT so an mtc0 EPC issued just before has landed.
      if (state_q == ST_COMMIT) newpc_q <= (code_q == EXC_ERET) ? epc_i : EXC_VECTOR;
    end
  end

  assign pc_o       = pc_q;
  assign dslot_o    = dslot_q;
  assign bad_addr_o = bad_q;
  assign newpc_o    = newpc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - randomized and directed bench for exc_ctrl against a behavioural model
module tb_exc_ctrl;

  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam int          DMAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_valid_i = 1'b0;
  logic [31:0] m_pc_i = '0;
  logic        m_dslot_i = 1'b0;
  logic [7:0]  m_flags_i = '0;
  logic [31:0] m_addr_i = '0;
  logic [31:0] status_i = '0;
  logic [31:0] cause_i = '0;
  logic [31:0] epc_i = '0;
  logic        fwd_we_i = 1'b0;
  logic [4:0]  fwd_addr_i = '0;
  logic [31:0] fwd_data_i = '0;
  logic        mem_busy_i = 1'b0;
  logic        if_ready_i = 1'b0;
  logic [31:0] excepttype_o, pc_o, bad_addr_o, newpc_o;
  logic        dslot_o, flush_o, stall_o, newpc_vld_o;

  int n_cmp = 0;
  int n_bad = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .m_valid_i(m_valid_i), .m_pc_i(m_pc_i), .m_dslot_i(m_dslot_i),
    .m_flags_i(m_flags_i), .m_addr_i(m_addr_i), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .fwd_we_i(fwd_we_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
    .mem_busy_i(mem_busy_i), .if_ready_i(if_ready_i), .excepttype_o(excepttype_o),
    .pc_o(pc_o), .dslot_o(dslot_o), .bad_addr_o(bad_addr_o), .flush_o(flush_o),
    .stall_o(stall_o), .newpc_o(newpc_o), .newpc_vld_o(newpc_vld_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_irq(input logic [31:0] st, input logic [31:0] ca, input logic we,
                                 input logic [4:0] a, input logic [31:0] d);
    logic [31:0] s, c;
    s = st;
    c = ca;
    if (we && a == 5'd12) s = d;
    if (we && a == 5'd13) c = (ca & ~32'h300) | (d & 32'h300);
    return ((((c >> 8) & (s >> 8)) & 32'hFF) != 0) && s[0] && !s[1];
  endfunction

  // Flag bit i is the (i+1)-th priority after interrupts; table gives its code.
  function automatic void ref_evt(input logic [7:0] f, input bit irq, input logic [31:0] pc,
                                  input logic [31:0] addr, output bit ev,
                                  output logic [31:0] code, output logic [31:0] bad);
    int codes [8];
    bit found;
    codes = '{4, 10, 12, 8, 9, 4, 5, 14};
    ev = irq; code = irq ? 32'd1 : 32'd0; bad = '0; found = irq;
    for (int i = 0; i < 8; i++) begin
      if (!found && f[i]) begin
        found = 1'b1;
        ev    = 1'b1;
        code  = 32'(codes[i]);
        bad   = (i == 0) ? pc : ((i == 5 || i == 6) ? addr : 32'd0);
      end
    end
  endfunction

  // Model: 0 idle, 1 waiting on bus, 2 commit, 3 redirect.
  int          m_ph = 0;
  int          m_drained = 0;
  logic [31:0] m_code = '0, m_pc = '0, m_bad = '0, m_newpc = '0;
  logic        m_dsl = 1'b0;

  always @(posedge clk or negedge rst) begin
    bit          ev;
    logic [31:0] c, b;
    if (!rst) begin
      m_ph = 0; m_drained = 0; m_code = '0; m_pc = '0; m_bad = '0; m_newpc = '0; m_dsl = 1'b0;
    end else begin
      case (m_ph)
        0: begin
          ref_evt(m_flags_i, ref_irq(status_i, cause_i, fwd_we_i, fwd_addr_i, fwd_data_i),
                  m_pc_i, m_addr_i, ev, c, b);
          if (m_valid_i && ev) begin
            m_code = c; m_bad = b; m_pc = m_pc_i; m_dsl = m_dslot_i;
            m_drained = 0; m_ph = 1;
          end
        end
        1: begin
          m_drained++;
          if (!mem_busy_i || m_drained >= DMAX) m_ph = 2;
        end
        2: begin
          m_newpc = (m_code == 32'd14) ? epc_i : VEC;
          m_ph = 3;
        end
        default: if (if_ready_i) m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("ctl", {29'd0, stall_o, flush_o, newpc_vld_o, excepttype_o},
          {29'd0, (m_ph == 1 || m_ph == 2), (m_ph == 2), (m_ph == 3),
           (m_ph == 2) ? m_code : 32'd0});
    if (m_ph == 2) check("latch", {pc_o, bad_addr_o ^ {31'd0, dslot_o}}, {m_pc, m_bad ^ {31'd0, m_dsl}});
    if (m_ph == 3) check("newpc", {32'd0, newpc_o}, {32'd0, m_newpc});
  end

  task automatic clear_inputs();
    m_valid_i = 0; m_pc_i = '0; m_dslot_i = 0; m_flags_i = '0; m_addr_i = '0;
    status_i = '0; cause_i = '0; epc_i = '0; fwd_we_i = 0; fwd_addr_i = '0;
    fwd_data_i = '0; mem_busy_i = 0; if_ready_i = 0;
  endtask

  task automatic directed(input string nm, input logic [7:0] flags, input logic [31:0] pc,
                          input logic [31:0] addr, input logic [31:0] st, input logic [31:0] ca,
                          input logic [31:0] epc, input logic fwe, input logic [31:0] fdata,
                          input int busy_n, input logic [31:0] exp_code,
                          input logic [31:0] exp_bad, input logic [31:0] exp_newpc,
                          input int exp_drain);
    int k, drains;
    bit done;
    @(negedge clk);
    m_valid_i = 1; m_flags_i = flags; m_pc_i = pc; m_addr_i = addr; m_dslot_i = 1;
    status_i = st; cause_i = ca; epc_i = epc; fwd_we_i = fwe; fwd_addr_i = 5'd12;
    fwd_data_i = fdata; mem_busy_i = (busy_n > 0); if_ready_i = 0;
    k = 0; drains = 0; done = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      m_valid_i = 0; m_flags_i = '0; fwd_we_i = 0;
      mem_busy_i = (k < busy_n);
      if (stall_o && !flush_o) drains++;
      if (flush_o) begin
        done = 1;
        check({nm, "_code"}, {32'd0, excepttype_o}, {32'd0, exp_code});
        check({nm, "_pc"}, {31'd0, dslot_o, pc_o}, {31'd0, 1'b1, pc});
        check({nm, "_bad"}, {32'd0, bad_addr_o}, {32'd0, exp_bad});
      end
    end
    if (!done) check({nm, "_timeout"}, 64'd0, 64'd1);
    check({nm, "_drain"}, 64'(drains), 64'(exp_drain));
    @(negedge clk);
    check({nm, "_redir"}, {31'd0, flush_o, newpc_vld_o, newpc_o}, {31'd0, 1'b0, 1'b1, exp_newpc});
    if_ready_i = 1;
    @(negedge clk);
    check({nm, "_idle"}, {63'd0, newpc_vld_o}, 64'd0);
    clear_inputs();
  endtask

  initial begin
    int flushes;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("reset", {28'd0, dslot_o, flush_o, stall_o, newpc_vld_o, excepttype_o | pc_o | bad_addr_o | newpc_o}, 64'd0);
    rst = 1;

    directed("sys",   8'h08, 32'h8000_1000, '0, '0, '0, '0, 0, '0, 0, 32'h08, 32'h0, VEC, 1);
    directed("eret",  8'h80, 32'h8000_0040, '0, '0, '0, 32'h8000_2004, 0, '0, 0, 32'h0e, 32'h0, 32'h8000_2004, 1);
    directed("intov", 8'h04, 32'h8000_0100, '0, '0, 32'h0000_0400, '0, 1, 32'h0000_FF01, 0, 32'h01, 32'h0, VEC, 1);
    directed("adel",  8'h20, 32'h8000_0200, 32'h8000_0003, '0, '0, '0, 0, '0, 3, 32'h04, 32'h8000_0003, VEC, 3);
    directed("stuck", 8'h10, 32'h8000_0300, '0, '0, '0, '0, 0, '0, 1000, 32'h09, 32'h0, VEC, 8);

    // Async reset while the redirect is pending.
    @(negedge clk);
    m_valid_i = 1; m_flags_i = 8'h02; m_pc_i = 32'h8000_0400;
    @(negedge clk);
    m_valid_i = 0; m_flags_i = '0;
    repeat (2) @(negedge clk);
    check("rst_pre", {63'd0, newpc_vld_o}, 64'd1);
    #2 rst = 0;
    #1 check("rst_async", {28'd0, dslot_o, flush_o, stall_o, newpc_vld_o, excepttype_o | pc_o | bad_addr_o | newpc_o}, 64'd0);
    @(negedge clk);
    rst = 1;
    flushes = 0;
    repeat (10) begin
      @(negedge clk);
      if (flush_o) flushes++;
    end
    check("rst_nocommit", 64'(flushes), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      m_valid_i  = ($urandom % 3) == 0;
      m_pc_i     = $urandom;
      m_dslot_i  = $urandom % 2;
      m_flags_i  = 8'($urandom & $urandom & $urandom);
      m_addr_i   = $urandom;
      status_i   = $urandom & 32'h0000_FF03;
      cause_i    = $urandom & $urandom & 32'h0000_FF00;
      epc_i      = $urandom;
      fwd_we_i   = ($urandom % 4) == 0;
      fwd_addr_i = ($urandom % 2) ? 5'(12 + ($urandom % 2)) : 5'($urandom);
      fwd_data_i = $urandom;
      mem_busy_i = (i % 400 < 60) ? 1'b1 : (($urandom % 3) != 0);
      if_ready_i = $urandom % 2;
    end
    clear_inputs();
    if_ready_i = 1;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
